// File: rtl/rr_arb2_mux_feed.sv
// -----------------------------------------------------------------------------
// rr_arb2_mux_feed
//
// Two-channel round-robin arbiter with a registered output stage. It sits
// directly in front of a 2:1 mux: the registered grant (sel) drives the mux
// select, and the selected word is presented on a single valid/ready output.
//
// Handshake semantics (all ports): a word moves on a rising clock edge when
// valid and ready are both high in the cycle before that edge. A producer
// holds valid/data stable until it sees ready. The consumer may change ready
// at any time. ready from this block never depends on rst being low for a
// transfer to complete: no transfer completes while rst is high.
//
// Ports
//   clk       : single clock, all state updates on posedge
//   rst       : synchronous, active-high reset
//   i0_valid  : channel 0 has a word
//   i0_data   : channel 0 word
//   i0_ready  : channel 0 word accepted this cycle
//   i1_valid  : channel 1 has a word
//   i1_data   : channel 1 word
//   i1_ready  : channel 1 word accepted this cycle
//   sel       : registered grant, 0 = i0, 1 = i1 (downstream mux select)
//   y_valid   : registered output word valid
//   y_data    : registered output word
//   y_ready   : downstream consumer accepts y_data
//   last_gnt  : channel that won the most recent transfer (priority state)
// -----------------------------------------------------------------------------
module rr_arb2_mux_feed #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i0_valid,
    input  logic [WIDTH-1:0] i0_data,
    output logic             i0_ready,
    input  logic             i1_valid,
    input  logic [WIDTH-1:0] i1_data,
    output logic             i1_ready,
    output logic             sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             last_gnt
);

    logic load;
    logic any_valid;
    logic gnt;

    // Output register is free, or its word leaves this same cycle.
    assign load      = ~y_valid | y_ready;
    assign any_valid = i0_valid | i1_valid;

    // Under contention the channel that did not win last time goes next.
    // With a single requester it wins outright. With no requester gnt is
    // unused (both readies gated by valid), so its value is irrelevant.
    always_comb begin
        gnt = 1'b0;
        if (i0_valid && i1_valid) begin
            gnt = ~last_gnt;
        end else if (i1_valid) begin
            gnt = 1'b1;
        end
    end

    // Gated by rst so that no handshake can appear to complete in a reset cycle.
    assign i0_ready = ~rst & load & i0_valid & ~gnt;
    assign i1_ready = ~rst & load & i1_valid &  gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid  <= 1'b0;
            y_data   <= '0;
            sel      <= 1'b0;
            last_gnt <= 1'b1;   // i0 has priority first after reset
        end else if (load) begin
            if (any_valid) begin
                y_data   <= gnt ? i1_data : i0_data;
                sel      <= gnt;
                last_gnt <= gnt;
                y_valid  <= 1'b1;
            end else begin
                // Drain (or stay idle): data and sel keep their last value.
                y_valid  <= 1'b0;
            end
        end
        // Stall (y_valid & ~y_ready): everything holds.
    end

endmodule

// File: tb/tb_rr_arb2_mux_feed.sv
// -----------------------------------------------------------------------------
// tb_rr_arb2_mux_feed
//
// Directed bench for rr_arb2_mux_feed. Inputs are driven 1 time unit after
// the rising edge; combinational readies and registered outputs are checked
// in the same window, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_rr_arb2_mux_feed;

    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst;
    logic             i0_valid;
    logic [WIDTH-1:0] i0_data;
    logic             i0_ready;
    logic             i1_valid;
    logic [WIDTH-1:0] i1_data;
    logic             i1_ready;
    logic             sel;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
    logic             last_gnt;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_arb2_mux_feed #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
        .sel      (sel),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_ready  (y_ready),
        .last_gnt (last_gnt)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1,
                         input logic yr);
        i0_valid = v0;
        i0_data  = d0;
        i1_valid = v1;
        i1_data  = d1;
        y_ready  = yr;
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic s);
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(v));
        chk({tag, ".y_data"},  32'(y_data),  32'(d));
        chk({tag, ".sel"},     32'(sel),     32'(s));
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".i0_ready"}, 32'(i0_ready), 32'(r0));
        chk({tag, ".i1_ready"}, 32'(i1_ready), 32'(r1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 8'h00, 1'b1);

        // 1. Reset held 2 cycles with both channels requesting.
        chk_rdy("rst_c0", 1'b0, 1'b0);
        step();
        chk_rdy("rst_c1", 1'b0, 1'b0);
        step();
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.last_gnt", 32'(last_gnt), 32'd1);
        chk_rdy("rst_c2", 1'b0, 1'b0);

        // 2. Single channel: i0 sends A5 then 3C back to back.
        rst = 1'b0;
        drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
        chk_rdy("single_a5", 1'b1, 1'b0);
        step();
        chk_out("single_a5", 1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        chk_rdy("single_3c", 1'b1, 1'b0);
        step();
        chk_out("single_3c", 1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk_rdy("drain", 1'b0, 1'b0);
        step();
        chk_out("drain", 1'b0, 8'h3C, 1'b0);
        chk("drain.last_gnt", 32'(last_gnt), 32'd0);

        // 3. Contention: i0 won last, so i1 goes first, then strict alternation.
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        chk_rdy("cont_first", 1'b0, 1'b1);
        step();
        chk_out("cont0", 1'b1, 8'h22, 1'b1);
        step();
        chk_out("cont1", 1'b1, 8'h11, 1'b0);
        step();
        chk_out("cont2", 1'b1, 8'h22, 1'b1);
        step();
        chk_out("cont3", 1'b1, 8'h11, 1'b0);

        // 4. Backpressure for 3 cycles: output frozen, nothing accepted.
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("stall", 1'b0, 1'b0);
            step();
            chk_out("stall", 1'b1, 8'h11, 1'b0);
            chk("stall.last_gnt", 32'(last_gnt), 32'd0);
        end
        // Release: i1 loads in the same cycle the held 11 drains.
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        chk_rdy("release", 1'b0, 1'b1);
        step();
        chk_out("release", 1'b1, 8'h22, 1'b1);

        // 5. Priority memory: i1 wins, idle 2 cycles, then i0 wins contention.
        drive(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
        step();
        chk_out("prio_i1", 1'b1, 8'h33, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        chk_out("idle0", 1'b0, 8'h33, 1'b1);
        step();
        chk_out("idle1", 1'b0, 8'h33, 1'b1);
        chk("idle.last_gnt", 32'(last_gnt), 32'd1);
        drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        chk_rdy("prio_both", 1'b1, 1'b0);
        step();
        chk_out("prio_both", 1'b1, 8'h44, 1'b0);

        // 6. Reset during a stall: pending word dropped, priority back to i0.
        drive(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
        step();
        chk_out("pre_rst_stall", 1'b1, 8'h44, 1'b0);
        rst = 1'b1;
        #1;
        chk_rdy("mid_rst", 1'b0, 1'b0);
        step();
        chk_out("mid_rst", 1'b0, 8'h00, 1'b0);
        chk("mid_rst.last_gnt", 32'(last_gnt), 32'd1);
        rst = 1'b0;
        drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
        chk_rdy("post_rst", 1'b1, 1'b0);
        step();
        chk_out("post_rst", 1'b1, 8'h66, 1'b0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
